// File: rtl/rst_seq.sv
// Power-up reset sequencer: holds all domains in reset, then releases them
// one at a time, waiting for each ready before the next, with timeout/loss abort.
module rst_seq #(
    parameter int NUM_DOM  = 4,
    parameter int HOLD_CYC = 64,
    parameter int GAP_CYC  = 16,
    parameter int TMO_CYC  = 1024,
    localparam int IW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1,
    localparam int M1 = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC,
    localparam int MX = (M1 > TMO_CYC) ? M1 : TMO_CYC,
    localparam int CW = (MX > 1) ? $clog2(MX) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               soft_rst_req,
    input  logic [NUM_DOM-1:0] dom_rdy,
    output logic [NUM_DOM-1:0] dom_rst_n,
    output logic               seq_done,
    output logic               seq_err,
    output logic [IW-1:0]      err_dom
);

    typedef enum logic [2:0] {
        S_HOLD,
        S_WAIT,
        S_GAP,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TMO_CYC - 1);
    localparam logic [IW-1:0] LAST_DOM  = IW'(NUM_DOM - 1);

    state_t               state_q, state_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [NUM_DOM-1:0]   rstn_q, rstn_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [IW-1:0]        edom_q, edom_d;

    logic                 loss;
    logic [IW-1:0]        loss_idx;

    // Lowest released domain that has dropped ready; DONE watches every domain.
    always_comb begin
        loss     = 1'b0;
        loss_idx = '0;
        for (int j = NUM_DOM - 1; j >= 0; j--) begin
            if (((state_q == S_DONE) || (j < int'(idx_q))) && !dom_rdy[j]) begin
                loss     = 1'b1;
                loss_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        rstn_d  = rstn_q;
        done_d  = done_q;
        err_d   = err_q;
        edom_d  = edom_q;
        if (soft_rst_req) begin
            state_d = S_HOLD;
            idx_d   = '0;
            cnt_d   = '0;
            rstn_d  = '0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            edom_d  = '0;
        end else begin
            unique case (state_q)
                S_HOLD: begin
                    rstn_d = '0;
                    if (cnt_q == HOLD_LAST) begin
                        rstn_d[0] = 1'b1;
                        idx_d     = '0;
                        cnt_d     = '0;
                        state_d   = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_WAIT: begin
                    if (loss) begin
                        state_d = S_ERROR;
                        edom_d  = loss_idx;
                    end else if (dom_rdy[idx_q]) begin
                        cnt_d = '0;
                        if (idx_q == LAST_DOM) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else if (cnt_q == TMO_LAST) begin
                        state_d = S_ERROR;
                        edom_d  = idx_q;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_GAP: begin
                    if (loss) begin
                        state_d = S_ERROR;
                        edom_d  = loss_idx;
                    end else if (cnt_q == GAP_LAST) begin
                        for (int j = 0; j < NUM_DOM; j++) begin
                            if (j == int'(idx_q) + 1) begin
                                rstn_d[j] = 1'b1;
                            end
                        end
                        idx_d   = idx_q + IW'(1);
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (loss) begin
                        state_d = S_ERROR;
                        edom_d  = loss_idx;
                    end
                end
                S_ERROR: begin
                    rstn_d = '0;
                end
                default: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                    rstn_d  = '0;
                end
            endcase
            if (state_d == S_ERROR && state_q != S_ERROR) begin
                rstn_d = '0;
                done_d = 1'b0;
                err_d  = 1'b1;
                cnt_d  = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_HOLD;
            idx_q   <= '0;
            cnt_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            edom_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
            err_q   <= err_d;
            edom_q  <= edom_d;
        end
    end

    assign dom_rst_n = rstn_q;
    assign seq_done  = done_q;
    assign seq_err   = err_q;
    assign err_dom   = edom_q;

endmodule

// File: tb/tb_rst_seq.sv
// Bench for rst_seq: a domain responder drives ready after each release and
// queues the release/done edge it expects; the monitor pops and compares.
module tb_rst_seq;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         soft_rst_req = 1'b0;
    logic [N-1:0] dom_rdy = '0;
    logic [N-1:0] dom_rst_n;
    logic         seq_done;
    logic         seq_err;
    logic [1:0]   err_dom;

    rst_seq #(
        .NUM_DOM (N),
        .HOLD_CYC(8),
        .GAP_CYC (4),
        .TMO_CYC (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .soft_rst_req(soft_rst_req),
        .dom_rdy     (dom_rdy),
        .dom_rst_n   (dom_rst_n),
        .seq_done    (seq_done),
        .seq_err     (seq_err),
        .err_dom     (err_dom)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int idx;
        int cyc;
    } ev_t;

    ev_t          sb[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int           rel_at[N];
    int           dly[N];
    logic [N-1:0] stall = '0;
    logic [N-1:0] drop = '0;
    logic [N-1:0] rdy_q = '0;
    logic [N-1:0] prev_n = '0;
    logic         prev_done = 1'b0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic sb_pop(input int idx);
        ev_t e;
        if (sb.size() == 0) begin
            check("sb_unexpected", idx, -1);
        end else begin
            e = sb.pop_front();
            check("sb_idx", idx, e.idx);
            check("sb_cyc", cyc, e.cyc);
        end
    endtask

    task automatic tick();
        ev_t e;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (dom_rst_n[i] && !prev_n[i]) begin
                rel_at[i] = cyc;
                sb_pop(i);
            end
        end
        if (seq_done && !prev_done) sb_pop(N);
        prev_n    = dom_rst_n;
        prev_done = seq_done;
        for (int i = 0; i < N; i++) begin
            if (!dom_rst_n[i]) begin
                rdy_q[i] = 1'b0;
            end else if (!rdy_q[i] && !stall[i] &&
                         cyc == rel_at[i] + dly[i]) begin
                rdy_q[i] = 1'b1;
                e.idx = i + 1;
                e.cyc = (i == N - 1) ? cyc + 1 : cyc + 5;
                sb.push_back(e);
            end
        end
        dom_rdy = rdy_q & ~drop;
    endtask

    task automatic restart();
        ev_t e;
        sb.delete();
        drop = '0;
        soft_rst_req = 1'b1;
        e.idx = 0;
        e.cyc = cyc + 9;
        sb.push_back(e);
        tick();
        soft_rst_req = 1'b0;
    endtask

    task automatic run_until_done();
        int n = 0;
        while (!seq_done && n < 200) begin
            tick();
            n++;
        end
        check("done_seen", int'(seq_done), 1);
        check("done_err", int'(seq_err), 0);
        check("done_rstn", int'(dom_rst_n), 15);
    endtask

    task automatic run_until_rel(input int i);
        int n = 0;
        while (!dom_rst_n[i] && n < 200) begin
            tick();
            n++;
        end
        check("rel_seen", int'(dom_rst_n[i]), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ev_t e;
        int  r;
        for (int i = 0; i < N; i++) begin
            dly[i]    = 3;
            rel_at[i] = 0;
        end
        rst = 1'b1;
        tick();
        check("rst_rstn", int'(dom_rst_n), 0);
        check("rst_done", int'(seq_done), 0);
        check("rst_err", int'(seq_err), 0);
        check("rst_edom", int'(err_dom), 0);
        tick();

        // nominal bring-up from rst release
        rst = 1'b0;
        e.idx = 0;
        e.cyc = cyc + 8;
        sb.push_back(e);
        run_until_done();
        repeat (3) tick();
        check("done_hold", int'(seq_done), 1);

        // timeout on domain 2
        stall[2] = 1'b1;
        restart();
        run_until_rel(2);
        r = cyc;
        for (int n = 0; n < 40 && !seq_err; n++) tick();
        check("tmo_cyc", cyc, r + 16);
        check("tmo_err", int'(seq_err), 1);
        check("tmo_edom", int'(err_dom), 2);
        check("tmo_rstn", int'(dom_rst_n), 0);
        check("tmo_done", int'(seq_done), 0);
        repeat (3) tick();
        check("err_hold", int'(seq_err), 1);
        stall = '0;

        // ready seen on the last timeout count is a success
        dly[1] = 15;
        restart();
        run_until_done();
        dly[1] = 3;

        // ready loss in DONE: lowest dropped domain is reported
        repeat (2) tick();
        drop = 4'b1001;
        dom_rdy = rdy_q & ~drop;
        tick();
        check("loss_err", int'(seq_err), 1);
        check("loss_edom", int'(err_dom), 0);
        check("loss_done", int'(seq_done), 0);
        check("loss_rstn", int'(dom_rst_n), 0);
        restart();
        run_until_done();
        drop = 4'b1100;
        dom_rdy = rdy_q & ~drop;
        tick();
        check("loss2_edom", int'(err_dom), 2);
        check("loss2_err", int'(seq_err), 1);

        // soft restart wins over a same-cycle timeout
        stall[2] = 1'b1;
        restart();
        run_until_rel(2);
        r = cyc;
        while (cyc < r + 15) tick();
        check("pri_pre_err", int'(seq_err), 0);
        stall = '0;
        restart();
        check("pri_err", int'(seq_err), 0);
        check("pri_rstn", int'(dom_rst_n), 0);
        run_until_done();

        // async reset between edges while in GAP
        restart();
        run_until_rel(0);
        r = cyc;
        while (cyc < r + 5) tick();
        check("gap_rstn", int'(dom_rst_n), 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_rstn", int'(dom_rst_n), 0);
        check("arst_done", int'(seq_done), 0);
        check("arst_err", int'(seq_err), 0);
        check("arst_edom", int'(err_dom), 0);
        sb.delete();
        repeat (3) tick();
        rst = 1'b0;
        e.idx = 0;
        e.cyc = cyc + 8;
        sb.push_back(e);
        run_until_done();

        check("sb_left", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 SHALL have parameter NUM_DOM, default 4: number of sequenced reset domains (A2D, inertial, balance ctrl, PWM).
REQ-002 SHALL have parameter HOLD_CYC, default 64: cycles all domains stay in reset after rst deasserts or a restart.
REQ-003 SHALL have parameter GAP_CYC, default 16: cycles between a domain's ready and the next domain's release.
REQ-004 SHALL have parameter TMO_CYC, default 1024: maximum cycles to wait for a released domain's ready.
REQ-005 SHALL have port clk, input, 1: sole clock; all state changes on the rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port soft_rst_req, input, 1: synchronous request to restart the whole sequence.
REQ-008 SHALL have port dom_rdy, input, NUM_DOM: per-domain ready, bit i from domain i; already synchronous to clk.
REQ-009 SHALL have port dom_rst_n, output, NUM_DOM: active-low per-domain reset, registered.
REQ-010 SHALL have port seq_done, output, 1: all domains released and ready, registered.
REQ-011 SHALL have port seq_err, output, 1: sequence aborted on timeout or ready loss, registered.
REQ-012 SHALL have port err_dom, output, clog2(NUM_DOM): index of failing domain, valid while seq_err=1.

Function
REQ-013 SHALL implement FSM states HOLD, WAIT, GAP, DONE, ERROR with one domain index idx and one cycle counter cnt.
REQ-014 HOLD: all dom_rst_n=0; cnt counts up from 0; when cnt=HOLD_CYC-1, set dom_rst_n[0]=1, idx=0, cnt=0 and go to WAIT.
REQ-015 WAIT: if dom_rdy[idx]=1 then go to GAP with cnt=0, or to DONE if idx=NUM_DOM-1; else if cnt=TMO_CYC-1 go to ERROR with err_dom=idx; else increment cnt.
REQ-016 Ready sampled in the same cycle as cnt=TMO_CYC-1 SHALL count as success, not timeout.
REQ-017 GAP: when cnt=GAP_CYC-1, set dom_rst_n[idx+1]=1, increment idx, cnt=0 and go to WAIT.
REQ-018 Releases SHALL be cumulative: dom_rst_n[j]=1 for all j<=idx while in WAIT, GAP or DONE; never released out of order.
REQ-019 In WAIT and GAP, dom_rdy[j]=0 for any j<idx SHALL go to ERROR with err_dom = lowest such j.
REQ-020 DONE: seq_done=1; dom_rdy[j]=0 for any j SHALL go to ERROR with err_dom = lowest such j and seq_done=0.
REQ-021 ERROR: all dom_rst_n=0, seq_err=1, err_dom held; remain until soft_rst_req.
REQ-022 soft_rst_req=1 in any state SHALL go to HOLD with cnt=0, all dom_rst_n=0, seq_done=0, seq_err=0 on the next edge.
REQ-023 soft_rst_req SHALL take priority over ready, timeout and ready-loss events in the same cycle.
REQ-024 A dom_rdy bit for an unreleased domain SHALL be ignored.
REQ-025 cnt width SHALL be clog2(max(HOLD_CYC, GAP_CYC, TMO_CYC)); cnt SHALL never wrap.
REQ-026 Latency from dom_rdy[i] high in WAIT to dom_rst_n[i+1] high SHALL be exactly GAP_CYC+1 edges.

Reset
REQ-027 rst=1 SHALL immediately force state HOLD, cnt=0, idx=0, dom_rst_n=0, seq_done=0, seq_err=0, err_dom=0, independent of clk.
REQ-028 rst asserted mid-sequence SHALL abort it; after rst deasserts, the sequence restarts from HOLD with a full HOLD_CYC.

Verification
Scenarios use NUM_DOM=4, HOLD_CYC=8, GAP_CYC=4, TMO_CYC=16.
REQ-029 Nominal: release rst; each dom_rdy[i] rises 3 cycles after dom_rst_n[i] rises -> dom_rst_n[0] high 8 edges after rst release; each later release 5 edges after the previous ready; seq_done=1; seq_err=0.
REQ-030 Timeout: dom_rdy[2] held 0 -> ERROR 16 edges after dom_rst_n[2] rises; dom_rst_n=4'b0000; seq_err=1; err_dom=2.
REQ-031 Boundary: dom_rdy[1] rises exactly on cnt=15 -> success, no error, GAP entered.
REQ-032 Ready loss: in DONE, dom_rdy[0] and dom_rdy[3] both drop in the same cycle -> err_dom=0; seq_done=0; dom_rst_n=0.
REQ-033 Priority: soft_rst_req and timeout in the same cycle -> HOLD, seq_err stays 0; full restart completes with seq_done=1.
REQ-034 Async reset: assert rst between clk edges during GAP -> outputs clear before the next edge; full HOLD_CYC observed after rst release.
